// File: rtl/uart_ctrl.sv
// UART controller: register file, TX/RX byte FIFOs and TX frame sequencer.
// Define UART_CTRL_IRQ_EN to build the IE register and the irq output.
module uart_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] CPB_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [15:0] cpb,
    output logic        tx_ena,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef logic [AW:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } tx_state_e;

    tx_state_e   state_q, state_d;
    logic [15:0] cpb_q, cpb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        ovr_q, ovr_d;
    ptr_t        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    ptr_t        rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];

    logic [2:0]  idx;
    logic        rd, wr;
    logic        tx_full, tx_empty, rx_full, rx_empty, busy;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [1:0]  ie_rd;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign idx = req_addr[4:2];
    assign rd  = req_valid & ~req_we;
    assign wr  = req_valid & req_we;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                      (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                      (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign busy     = (state_q != S_IDLE);

    // Full is sampled before this cycle's pops, so a push into a full FIFO drops.
    assign tx_push = wr && (idx == 3'd2) && !tx_full;
    assign rx_pop  = rd && (idx == 3'd1) && !rx_empty;
    assign rx_push = rx_done && (!rx_full || rx_pop);

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_data_d = tx_mem[tx_rp_q[AW-1:0]];
                    state_d   = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT:  if (tx_done) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_wp_d = tx_wp_q + (tx_push ? PTR_ONE : '0);
        tx_rp_d = tx_rp_q + (tx_pop  ? PTR_ONE : '0);
        rx_wp_d = rx_wp_q + (rx_push ? PTR_ONE : '0);
        rx_rp_d = rx_rp_q + (rx_pop  ? PTR_ONE : '0);
    end

    always_comb begin
        cpb_d = cpb_q;
        ovr_d = ovr_q;
        if (wr && (idx == 3'd0)) cpb_d = req_wdata[15:0];
        if (wr && (idx == 3'd3) && req_wdata[4]) ovr_d = 1'b0;
        if (rx_done && rx_full && !rx_pop) ovr_d = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (idx)
            3'd0: rd_mux = {16'h0, cpb_q};
            3'd1: rd_mux = rx_empty ? 32'h0
                                    : {24'h0, rx_mem[rx_rp_q[AW-1:0]]};
            3'd3: rd_mux = {27'h0, ovr_q, busy, tx_empty, tx_full, !rx_empty};
            3'd4: rd_mux = {30'h0, ie_rd};
            default: rd_mux = '0;
        endcase
        rdata_d       = rd ? rd_mux : rdata_q;
        rdata_valid_d = rd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cpb_q         <= CPB_RESET;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            tx_data_q     <= '0;
            ovr_q         <= 1'b0;
            tx_wp_q       <= '0;
            tx_rp_q       <= '0;
            rx_wp_q       <= '0;
            rx_rp_q       <= '0;
        end else begin
            state_q       <= state_d;
            cpb_q         <= cpb_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            tx_data_q     <= tx_data_d;
            ovr_q         <= ovr_d;
            tx_wp_q       <= tx_wp_d;
            tx_rp_q       <= tx_rp_d;
            rx_wp_q       <= rx_wp_d;
            rx_rp_q       <= rx_rp_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= req_wdata[7:0];
        if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_data;
    end

`ifdef UART_CTRL_IRQ_EN
    logic [1:0] ie_q, ie_d;
    logic       irq_q, irq_d;

    always_comb begin
        ie_d = ie_q;
        if (wr && (idx == 3'd4)) ie_d = req_wdata[1:0];
        irq_d = (ie_q[0] & !rx_empty) |
                (ie_q[1] & tx_empty & !busy) |
                ovr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie_rd = ie_q;
    assign irq   = irq_q;
`else
    assign ie_rd = 2'b00;
    assign irq   = 1'b0;
`endif

    // No start pulse may leak out while reset is being applied.
    assign tx_ena      = (state_q == S_START) && rst;
    assign tx_data     = tx_data_q;
    assign cpb         = cpb_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

    assign unused_bits = ^{req_addr[1:0], req_wdata[31:16]};

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: directed scenarios plus a randomized
// bus/RX/TX mix checked against queue-based reference behaviour.
module tb_uart_ctrl;

    localparam int DEPTH = 8;
    localparam logic [4:0] A_CPB  = 5'h00;
    localparam logic [4:0] A_RDR  = 5'h04;
    localparam logic [4:0] A_TDR  = 5'h08;
    localparam logic [4:0] A_STAT = 5'h0C;
    localparam logic [4:0] A_IE   = 5'h10;
    localparam logic [4:0] A_RSV  = 5'h14;

    logic        clk, rst;
    logic        req_valid, req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata, rdata;
    logic        rdata_valid;
    logic [15:0] cpb;
    logic        tx_ena, tx_done, rx_done, irq;
    logic [7:0]  tx_data, rx_data;

    uart_ctrl #(.FIFO_DEPTH(DEPTH), .CPB_RESET(16'd868)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .cpb(cpb), .tx_ena(tx_ena), .tx_data(tx_data),
        .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done),
        .irq(irq)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // transmitter stand-in and frame monitor
    logic [7:0] got_q[$];
    int         ena_cyc_q[$];
    int         done_cyc_q[$];
    logic [7:0] cur_byte;
    bit         in_frame = 0;
    bit         pending  = 0;
    bit         hold     = 0;
    int         due      = 0;
    int         lat_min  = 10;
    int         lat_max  = 10;
    int         stab_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (tx_ena) begin
                got_q.push_back(tx_data);
                ena_cyc_q.push_back(cyc);
                cur_byte = tx_data;
                in_frame = 1;
                pending  = 1;
                due      = cyc + int'($urandom_range(lat_min, lat_max));
            end else if (in_frame && tx_data !== cur_byte) begin
                stab_err++;
            end
            if (tx_done) begin
                done_cyc_q.push_back(cyc);
                in_frame = 0;
            end
        end
    end

    initial begin
        tx_done = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 0;
            if (pending && !hold && cyc >= due) begin
                tx_done = 1;
                pending = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
        step();
        req_valid = 0; req_we = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        req_valid = 1; req_we = 0; req_addr = a;
        step();
        req_valid = 0;
        check("rvalid", 32'(rdata_valid), 1);
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_done = 1; rx_data = b;
        step();
        rx_done = 0;
    endtask

    task automatic clear_mon();
        got_q.delete();
        ena_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while ((got_q.size() < n || done_cyc_q.size() < n) && k < budget) begin
            step();
            k++;
        end
        check("frame_cnt", 32'(got_q.size()), 32'(n));
        check("done_cnt", 32'(done_cyc_q.size()), 32'(n));
    endtask

    // reference state for the randomized phase
    logic [7:0]  mq[$];
    logic [7:0]  tx_exp[$];
    bit          movr;
    logic [15:0] mcpb;
    int          op, lat, k;
    bit          do_rx, is_rd, cpb_wr;
    logic [7:0]  rb;
    logic [31:0] w, rexp, rmask;
    string       tg;

    initial begin
        rst = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        rx_done = 0; rx_data = 0;
        step(); step();
        rst = 1;

        check("rst_cpb", 32'(cpb), 32'd868);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", 32'(rdata_valid), 0);
        check("rst_txena", 32'(tx_ena), 0);
        check("rst_txdata", 32'(tx_data), 0);
        check("rst_irq", 32'(irq), 0);
        rd_chk("rst_stat", A_STAT, 32'h4);

        wr(A_CPB, 32'h1234);
        check("cpb_port", 32'(cpb), 32'h1234);
        rd_chk("cpb_rd", A_CPB, 32'h1234);
        rst = 0;
        step();
        rst = 1;
        rd_chk("cpb_after_rst", A_CPB, 32'h364);
        rd_chk("stat_after_rst", A_STAT, 32'h4);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd_chk("rsv_rd", A_RSV, 0);
        rd_chk("tdr_rd", A_TDR, 0);
        rd_chk("rdr_empty", A_RDR, 0);

        // reset while a frame is being started, second byte still queued
        clear_mon();
        hold = 1;
        wr(A_TDR, 32'h77);
        wr(A_TDR, 32'h66);
        rst = 0; in_frame = 0; pending = 0;
        @(negedge clk);
        check("rst_no_ena", 32'(tx_ena), 0);
        step();
        rst = 1;
        repeat (20) step();
        check("rst_frames", 32'(got_q.size()), 0);
        rd_chk("rst_stat2", A_STAT, 32'h4);
        hold = 0;

        // TX burst
        clear_mon();
        k = cyc;
        wr(A_TDR, 32'h55);
        wr(A_TDR, 32'hAA);
        wr(A_TDR, 32'h0F);
        wait_frames(3, 300);
        if (got_q.size() >= 3 && done_cyc_q.size() >= 3) begin
            check("burst_b0", 32'(got_q[0]), 32'h55);
            check("burst_b1", 32'(got_q[1]), 32'hAA);
            check("burst_b2", 32'(got_q[2]), 32'h0F);
            lat = ena_cyc_q[0] - k;
            check("first_lat", 32'(lat >= 2 && lat <= 3), 1);
            check("b2b_gap1", 32'(ena_cyc_q[1] - done_cyc_q[0]), 3);
            check("b2b_gap2", 32'(ena_cyc_q[2] - done_cyc_q[1]), 3);
        end
        step(); step();
        rd_chk("burst_stat", A_STAT, 32'h4);

        // TX overflow with tx_done withheld
        clear_mon();
        hold = 1;
        for (int i = 0; i < 10; i++) wr(A_TDR, 32'(i));
        rd_chk("ovf_stat", A_STAT, 32'h0A);
        hold = 0;
        wait_frames(9, 600);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            check("ovf_byte", 32'(got_q[i]), 32'(i));
        repeat (15) step();
        check("ovf_no_extra", 32'(got_q.size()), 9);
        rd_chk("ovf_stat2", A_STAT, 32'h4);

        // RX overflow
        for (int i = 0; i < 9; i++) rx_pulse(8'h10 + 8'(i));
        rd_chk("rxovf_stat", A_STAT, 32'h15);
        for (int i = 0; i < 8; i++) rd_chk("rxovf_rd", A_RDR, 32'h10 + 32'(i));
        rd_chk("rxovf_empty", A_RDR, 0);
        wr(A_STAT, 32'h10);
        rd_chk("ovr_clr", A_STAT, 32'h4);

        // simultaneous push/pop on a full RX FIFO
        for (int i = 0; i < 8; i++) rx_pulse(8'h20 + 8'(i));
        rx_done = 1; rx_data = 8'h99;
        rd_chk("full_pp_rd", A_RDR, 32'h20);
        rx_done = 0;
        rd_chk("full_pp_stat", A_STAT, 32'h5);
        for (int i = 1; i < 8; i++) rd_chk("full_pp_seq", A_RDR, 32'h20 + 32'(i));
        rd_chk("full_pp_last", A_RDR, 32'h99);
        rd_chk("full_pp_empty", A_RDR, 0);

        // simultaneous push/pop on an empty RX FIFO
        rx_done = 1; rx_data = 8'h42;
        rd_chk("empty_pp_rd", A_RDR, 0);
        rx_done = 0;
        rd_chk("empty_pp_stored", A_RDR, 32'h42);

`ifdef UART_CTRL_IRQ_EN
        wr(A_IE, 32'h1);
        rd_chk("ie_rd", A_IE, 32'h1);
        check("irq_idle", 32'(irq), 0);
        rx_pulse(8'h5A);
        step();
        check("irq_rx", 32'(irq), 1);
        rd_chk("irq_rdr", A_RDR, 32'h5A);
        check("irq_hold", 32'(irq), 1);
        step();
        check("irq_clr", 32'(irq), 0);
        wr(A_IE, 32'h2);
        step();
        check("irq_txe", 32'(irq), 1);
        wr(A_IE, 32'h0);
        step();
        check("irq_off", 32'(irq), 0);
`else
        wr(A_IE, 32'h3);
        rd_chk("ie_rd", A_IE, 0);
        rx_pulse(8'h5A);
        step(); step();
        check("irq_tied", 32'(irq), 0);
        rd_chk("irq_rdr", A_RDR, 32'h5A);
`endif

        // randomized mix
        rst = 0; in_frame = 0; pending = 0;
        step();
        rst = 1;
        mq.delete(); tx_exp.delete(); clear_mon();
        movr = 0; mcpb = 16'h364;
        lat_min = 1; lat_max = 12;
        for (int i = 0; i < 1500; i++) begin
            op = int'($urandom_range(0, 9));
            do_rx = ($urandom_range(0, 9) < 4);
            rb = 8'($urandom);
            w = $urandom;
            is_rd = 0; cpb_wr = 0; rexp = 0; rmask = 32'hFFFF_FFFF; tg = "";
            if (op == 7) do_rx = 0;
            case (op)
                0, 1, 2, 3: begin
                    req_valid = 1; req_we = 0; req_addr = A_RDR;
                    is_rd = 1; tg = "rnd_rdr";
                    if (mq.size() > 0) rexp = 32'(mq.pop_front());
                end
                4, 5: begin
                    if (tx_exp.size() - got_q.size() < DEPTH) begin
                        req_valid = 1; req_we = 1; req_addr = A_TDR;
                        req_wdata = w;
                        tx_exp.push_back(w[7:0]);
                    end
                end
                6: begin
                    req_valid = 1; req_we = 0; req_addr = A_STAT;
                    is_rd = 1; tg = "rnd_stat"; rmask = 32'h11;
                    rexp = {27'h0, movr, 3'b000, mq.size() > 0};
                end
                7: begin
                    req_valid = 1; req_we = 1; req_addr = A_STAT;
                    req_wdata = w;
                    if (w[4]) movr = 0;
                end
                8: begin
                    req_valid = 1; req_we = 1; req_addr = A_CPB;
                    req_wdata = w; mcpb = w[15:0]; cpb_wr = 1;
                end
                default: begin
                    req_valid = 1; req_we = 0; req_addr = A_CPB;
                    is_rd = 1; tg = "rnd_cpb"; rexp = {16'h0, mcpb};
                end
            endcase
            if (do_rx) begin
                rx_done = 1; rx_data = rb;
                if (mq.size() < DEPTH) mq.push_back(rb);
                else movr = 1;
            end
            step();
            req_valid = 0; req_we = 0; rx_done = 0;
            if (is_rd) begin
                check("rnd_rvalid", 32'(rdata_valid), 1);
                check(tg, rdata & rmask, rexp);
            end
            if (cpb_wr) check("rnd_cpb_port", 32'(cpb), 32'(mcpb));
        end
        k = 0;
        while (got_q.size() < tx_exp.size() && k < 3000) begin
            step();
            k++;
        end
        check("rnd_tx_cnt", 32'(got_q.size()), 32'(tx_exp.size()));
        for (int i = 0; i < tx_exp.size() && i < got_q.size(); i++)
            check("rnd_tx_byte", 32'(got_q[i]), 32'(tx_exp[i]));
        check("tx_stable", 32'(stab_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
